// File: rtl/iir_pkg.sv
// Shared types and width helpers for the TDM biquad filter.
// Saturation is selected at build time with IIR_SATURATE_EN.
package iir_pkg;

  typedef enum logic [2:0] {
    COEF_B0 = 3'd0,
    COEF_B1 = 3'd1,
    COEF_B2 = 3'd2,
    COEF_A1 = 3'd3,
    COEF_A2 = 3'd4
  } coef_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int op_w(input int win, input int wout);
    return (win > wout) ? win : wout;
  endfunction

  function automatic int prod_w(input int win, input int wout,
                                input int wc);
    return op_w(win, wout) + wc;
  endfunction

  function automatic int acc_w(input int win, input int wout,
                               input int wc, input int g);
    return prod_w(win, wout, wc) + g;
  endfunction

endpackage

// File: rtl/iir_biquad_tdm_if.sv
// Sample, coefficient and result signals of the TDM biquad.
interface iir_biquad_tdm_if #(
  parameter int WIN   = 17,
  parameter int WOUT  = 17,
  parameter int WCOEF = 17,
  parameter int CHW   = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CHW-1:0]          in_ch;
  logic signed [WIN-1:0]   x;
  logic                    coef_we;
  logic [2:0]              coef_sel;
  logic signed [WCOEF-1:0] coef_data;
  logic                    out_valid;
  logic [CHW-1:0]          out_ch;
  logic signed [WOUT-1:0]  y;
  logic                    ovf;

  modport master (
    output in_valid, in_ch, x,
    output coef_we, coef_sel, coef_data,
    input  in_ready, out_valid, out_ch, y, ovf
  );

  modport slave (
    input  in_valid, in_ch, x,
    input  coef_we, coef_sel, coef_data,
    output in_ready, out_valid, out_ch, y, ovf
  );
endinterface

// File: rtl/iir_mac.sv
// Signed multiply-accumulate with clear, then shift/fit to output width.
// IIR_SATURATE_EN selects clipping instead of two's-complement wrap.
module iir_mac #(
  parameter int OPW   = 17,
  parameter int WCOEF = 17,
  parameter int GUARD = 4,
  parameter int FRAC  = 16,
  parameter int WOUT  = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    sub_i,
  input  logic signed [OPW-1:0]   op_i,
  input  logic signed [WCOEF-1:0] coef_i,
  output logic signed [WOUT-1:0]  q_o,
  output logic                    ovf_o
);
  localparam int PW = OPW + WCOEF;
  localparam int AW = PW + GUARD;
  localparam int SW = AW - FRAC;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_x;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [SW-1:0]        sh;
  logic                 fits;

  assign prod   = op_i * coef_i;
  assign prod_x = {{GUARD{prod[PW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) acc_d = '0;
    else if (en_i && sub_i) acc_d = acc_q - prod_x;
    else if (en_i) acc_d = acc_q + prod_x;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // Dropping the low FRAC bits is an arithmetic shift (floor).
  assign sh    = acc_q[AW-1:FRAC];
  assign fits  = (&sh[SW-1:WOUT-1]) | ~(|sh[SW-1:WOUT-1]);
  assign ovf_o = ~fits;

`ifdef IIR_SATURATE_EN
  always_comb begin
    q_o = sh[WOUT-1:0];
    if (!fits && sh[SW-1])  q_o = {1'b1, {(WOUT-1){1'b0}}};
    if (!fits && !sh[SW-1]) q_o = {1'b0, {(WOUT-1){1'b1}}};
  end
`else
  assign q_o = sh[WOUT-1:0];
`endif
endmodule

// File: rtl/iir_biquad_tdm.sv
// Direct-form-I biquad shared by NUM_CH channels over one MAC.
// Build with IIR_SATURATE_EN to clip instead of wrap on overflow.
module iir_biquad_tdm
  import iir_pkg::*;
#(
  parameter int WORD_LEN_IN    = 17,
  parameter int WORD_FRAC_IN   = 16,
  parameter int WORD_LEN_OUT   = 17,
  parameter int WORD_FRAC_OUT  = 16,
  parameter int WORD_LEN_COEF  = 17,
  parameter int WORD_FRAC_COEF = 16,
  parameter int ACC_GUARD      = 4,
  parameter int NUM_CH         = 4
) (
  input logic              clk,
  input logic              reset,
  iir_biquad_tdm_if.slave  bus
);
  localparam int CH_W = ch_w(NUM_CH);
  localparam int OPW  = op_w(WORD_LEN_IN, WORD_LEN_OUT);
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

  if (WORD_FRAC_OUT != WORD_FRAC_IN) begin : g_frac_chk
    $error("WORD_FRAC_OUT must equal WORD_FRAC_IN");
  end
  if (NUM_CH < 1) begin : g_nch_chk
    $error("NUM_CH must be at least 1");
  end

  state_e state_q, state_d;
  coef_e  tap_q, tap_d;

  logic [CH_W-1:0]                 ch_q, idx, out_ch_q;
  logic signed [WORD_LEN_IN-1:0]   x_q;
  logic signed [WORD_LEN_COEF-1:0] coef_q [5];
  logic signed [WORD_LEN_IN-1:0]   x1_q [NUM_CH];
  logic signed [WORD_LEN_IN-1:0]   x2_q [NUM_CH];
  logic signed [WORD_LEN_OUT-1:0]  y1_q [NUM_CH];
  logic signed [WORD_LEN_OUT-1:0]  y2_q [NUM_CH];
  logic signed [WORD_LEN_OUT-1:0]  y_q, mac_q;
  logic signed [OPW-1:0]           op;
  logic signed [WORD_LEN_COEF-1:0] cf;
  logic in_ready, accept, ch_ok, sub;
  logic out_valid_q, ovf_q, mac_ovf;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_ready && bus.in_valid;
  assign ch_ok    = ({1'b0, ch_q} < NCH);
  assign idx      = ch_ok ? ch_q : '0;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        state_d = ST_MAC;
        tap_d   = COEF_B0;
      end
      ST_MAC: begin
        tap_d = coef_e'(tap_q + 3'd1);
        if (tap_q == COEF_A2) begin
          state_d = ST_OUT;
          tap_d   = COEF_B0;
        end
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Out-of-range channels run against zero history.
  always_comb begin
    op  = '0;
    cf  = '0;
    sub = 1'b0;
    unique case (tap_q)
      COEF_B0: begin op = x_q; cf = coef_q[0]; end
      COEF_B1: begin
        op = ch_ok ? x1_q[idx] : '0;
        cf = coef_q[1];
      end
      COEF_B2: begin
        op = ch_ok ? x2_q[idx] : '0;
        cf = coef_q[2];
      end
      COEF_A1: begin
        op  = ch_ok ? y1_q[idx] : '0;
        cf  = coef_q[3];
        sub = 1'b1;
      end
      COEF_A2: begin
        op  = ch_ok ? y2_q[idx] : '0;
        cf  = coef_q[4];
        sub = 1'b1;
      end
      default: ;
    endcase
  end

  iir_mac #(
    .OPW   (OPW),
    .WCOEF (WORD_LEN_COEF),
    .GUARD (ACC_GUARD),
    .FRAC  (WORD_FRAC_COEF),
    .WOUT  (WORD_LEN_OUT)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept),
    .en_i   (state_q == ST_MAC),
    .sub_i  (sub),
    .op_i   (op),
    .coef_i (cf),
    .q_o    (mac_q),
    .ovf_o  (mac_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tap_q       <= COEF_B0;
      ch_q        <= '0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < 5; i++) coef_q[i] <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      out_valid_q <= 1'b0;
      if (accept) begin
        ch_q <= bus.in_ch;
        x_q  <= bus.x;
      end
      if (in_ready && bus.coef_we && bus.coef_sel <= 3'd4)
        coef_q[bus.coef_sel] <= bus.coef_data;
      if (state_q == ST_OUT && ch_ok) begin
        x2_q[idx]   <= x1_q[idx];
        x1_q[idx]   <= x_q;
        y2_q[idx]   <= y1_q[idx];
        y1_q[idx]   <= mac_q;
        y_q         <= mac_q;
        ovf_q       <= mac_ovf;
        out_ch_q    <= ch_q;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Scoreboard bench for iir_biquad_tdm (Q1.16, three channels).
// Expected results come from a longint reference of the difference equation.
`timescale 1ns/1ps
module tb_iir_biquad_tdm;
  import iir_pkg::*;

  localparam int NCH = 3;

  typedef struct packed {
    logic [1:0]  ch;
    logic [16:0] y;
    logic        ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iir_biquad_tdm_if #(.WIN(17), .WOUT(17), .WCOEF(17), .CHW(2)) bus ();

  iir_biquad_tdm #(
    .WORD_LEN_IN(17), .WORD_FRAC_IN(16),
    .WORD_LEN_OUT(17), .WORD_FRAC_OUT(16),
    .WORD_LEN_COEF(17), .WORD_FRAC_COEF(16),
    .ACC_GUARD(4), .NUM_CH(NCH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t   sb [$];
  longint mcoef [5];
  longint mx1 [NCH], mx2 [NCH], my1 [NCH], my2 [NCH];
  int     n_chk  = 0;
  int     n_pass = 0;

  function automatic longint sx17(input logic [16:0] v);
    return longint'($signed(v));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) mcoef[i] = 0;
    for (int c = 0; c < NCH; c++) begin
      mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
    end
    sb.delete();
  endtask

  // Computes y for a sample and queues it; dropped channels queue nothing.
  task automatic model_push(input int ch, input logic [16:0] xv);
    longint acc, sh;
    logic [16:0] yq;
    exp_t e;
    if (ch < NCH) begin
      acc = mcoef[0] * sx17(xv) + mcoef[1] * mx1[ch]
          + mcoef[2] * mx2[ch] - mcoef[3] * my1[ch]
          - mcoef[4] * my2[ch];
      sh = acc >>> 16;
      yq = sh[16:0];
`ifdef IIR_SATURATE_EN
      if (sh > 65535)  yq = 17'h0FFFF;
      if (sh < -65536) yq = 17'h10000;
`endif
      mx2[ch] = mx1[ch];
      mx1[ch] = sx17(xv);
      my2[ch] = my1[ch];
      my1[ch] = sx17(yq);
      e.ch  = ch[1:0];
      e.y   = yq;
      e.ovf = (sh > 65535) || (sh < -65536);
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic wr_coef(input logic [2:0] sel, input logic [16:0] d);
    bus.coef_we   = 1'b1;
    bus.coef_sel  = sel;
    bus.coef_data = d;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    if (sel <= 3'd4) mcoef[sel] = sx17(d);
  endtask

  // Offers one sample; optionally strobes coef_we at edge E<wr_cyc>.
  task automatic run_sample(
    input  logic [1:0]  ch,
    input  logic [16:0] xv,
    input  int          wr_cyc,
    input  logic [2:0]  wsel,
    input  logic [16:0] wdat,
    output bit          seen,
    output int          lat,
    output int          rl,
    output logic [16:0] yo,
    output logic [1:0]  co,
    output logic        oo
  );
    seen = 1'b0; lat = 0; rl = 0;
    yo = '0; co = '0; oo = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_ch    = ch;
    bus.x        = xv;
    if (wr_cyc == 0) begin
      bus.coef_we = 1'b1; bus.coef_sel = wsel; bus.coef_data = wdat;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (wr_cyc == k) begin
        bus.coef_we = 1'b1; bus.coef_sel = wsel; bus.coef_data = wdat;
      end
      @(posedge clk);
      #1;
      bus.coef_we = 1'b0;
      if (bus.out_valid && !seen) begin
        seen = 1'b1; lat = k;
        yo = bus.y; co = bus.out_ch; oo = bus.ovf;
      end
      if (bus.in_ready && rl == 0) rl = k;
      if (rl != 0) break;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.y, bus.out_ch, bus.ovf}
        !== {1'b1, 1'b0, 17'h0, 2'd0, 1'b0})
      $display("FAIL reset_state got rdy=%b ov=%b y=%h ch=%0d ovf=%b expected 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.y, bus.out_ch, bus.ovf);
    else n_pass++;
  endtask

  task automatic test_single();
    bit seen; int lat, rl; logic [16:0] yo; logic [1:0] co; logic oo; exp_t e;
    do_reset();
    wr_coef(COEF_B0, 17'h08000);
    model_push(0, 17'h08000);
    run_sample(2'd0, 17'h08000, -1, 3'd0, 17'h0, seen, lat, rl, yo, co, oo);
    e = sb.pop_front();
    n_chk++;
    if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf})
      $display("FAIL single got v=%b ch=%0d y=%h ovf=%b expected ch=%0d y=%h ovf=%b",
               seen, co, yo, oo, e.ch, e.y, e.ovf);
    else n_pass++;
    n_chk++;
    if (yo !== 17'h04000)
      $display("FAIL single_const got y=%h expected 04000", yo);
    else n_pass++;
    n_chk++;
    if (lat !== 6 || rl !== 6)
      $display("FAIL latency got out=%0d ready=%0d expected 6 6", lat, rl);
    else n_pass++;
  endtask

  task automatic test_impulse();
    bit seen; int lat, rl; logic [16:0] yo; logic [1:0] co; logic oo; exp_t e;
    logic [16:0] imp [3];
    logic [16:0] xv;
    imp = '{17'h04000, 17'h02000, 17'h01000};
    do_reset();
    wr_coef(COEF_B0, 17'h08000);
    wr_coef(COEF_A1, 17'h18000);
    for (int i = 0; i < 3; i++) begin
      xv = (i == 0) ? 17'h08000 : 17'h0;
      model_push(0, xv);
      run_sample(2'd0, xv, -1, 3'd0, 17'h0, seen, lat, rl, yo, co, oo);
      e = sb.pop_front();
      n_chk++;
      if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf} || yo !== imp[i])
        $display("FAIL impulse[%0d] got v=%b y=%h ovf=%b expected y=%h/%h ovf=%b",
                 i, seen, yo, oo, e.y, imp[i], e.ovf);
      else n_pass++;
    end
  endtask

  // Back-to-back samples: each offer lands on the first ready edge.
  task automatic test_interleave();
    bit seen; int lat, rl; logic [16:0] yo; logic [1:0] co; logic oo; exp_t e;
    logic [16:0] imp [3];
    logic [16:0] xv;
    imp = '{17'h04000, 17'h02000, 17'h01000};
    do_reset();
    wr_coef(COEF_B0, 17'h08000);
    wr_coef(COEF_A1, 17'h18000);
    for (int i = 0; i < 16; i++) begin
      xv = (i == 0) ? 17'h08000 : 17'h0;
      model_push(0, xv);
      run_sample(2'd0, xv, -1, 3'd0, 17'h0, seen, lat, rl, yo, co, oo);
      e = sb.pop_front();
      n_chk++;
      if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf} ||
          (i < 3 && yo !== imp[i]))
        $display("FAIL ilv_ch0[%0d] got v=%b ch=%0d y=%h expected y=%h",
                 i, seen, co, yo, e.y);
      else n_pass++;
      model_push(1, 17'h04000);
      run_sample(2'd1, 17'h04000, -1, 3'd0, 17'h0, seen, lat, rl, yo, co, oo);
      e = sb.pop_front();
      n_chk++;
      if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf})
        $display("FAIL ilv_ch1[%0d] got v=%b ch=%0d y=%h expected y=%h",
                 i, seen, co, yo, e.y);
      else n_pass++;
    end
    n_chk++;
    if (yo < 17'h03FFF || yo > 17'h04000)
      $display("FAIL ilv_converge got y=%h expected 03fff..04000", yo);
    else n_pass++;
  endtask

  task automatic test_overflow();
    bit seen; int lat, rl; logic [16:0] yo; logic [1:0] co; logic oo; exp_t e;
    logic [16:0] yexp;
`ifdef IIR_SATURATE_EN
    yexp = 17'h0FFFF;
`else
    yexp = 17'h1FFFC;
`endif
    do_reset();
    wr_coef(COEF_B0, 17'h0FFFF);
    wr_coef(COEF_B1, 17'h0FFFF);
    for (int i = 0; i < 2; i++) begin
      model_push(2, 17'h0FFFF);
      run_sample(2'd2, 17'h0FFFF, -1, 3'd0, 17'h0, seen, lat, rl, yo, co, oo);
      e = sb.pop_front();
      n_chk++;
      if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf})
        $display("FAIL ovf_model[%0d] got v=%b ch=%0d y=%h ovf=%b expected ch=%0d y=%h ovf=%b",
                 i, seen, co, yo, oo, e.ch, e.y, e.ovf);
      else n_pass++;
    end
    n_chk++;
    if (yo !== yexp || oo !== 1'b1)
      $display("FAIL ovf_const got y=%h ovf=%b expected y=%h ovf=1", yo, oo, yexp);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen; int lat, rl; logic [16:0] yo; logic [1:0] co; logic oo; exp_t e;
    int nv;
    do_reset();
    wr_coef(COEF_B0, 17'h08000);
    bus.in_valid = 1'b1; bus.in_ch = 2'd0; bus.x = 17'h08000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    nv = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) nv++;
    end
    n_chk++;
    if (nv !== 0)
      $display("FAIL mid_reset_out got %0d strobes expected 0", nv);
    else n_pass++;
    n_chk++;
    if ({bus.in_ready, bus.y} !== {1'b1, 17'h0})
      $display("FAIL mid_reset_state got rdy=%b y=%h expected 1 00000",
               bus.in_ready, bus.y);
    else n_pass++;
    model_push(1, 17'h0ABCD);
    run_sample(2'd1, 17'h0ABCD, -1, 3'd0, 17'h0, seen, lat, rl, yo, co, oo);
    e = sb.pop_front();
    n_chk++;
    if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf} || yo !== 17'h0)
      $display("FAIL mid_reset_coef got v=%b ch=%0d y=%h expected ch=%0d y=00000",
               seen, co, yo, e.ch);
    else n_pass++;
  endtask

  task automatic test_coef_write();
    bit seen; int lat, rl; logic [16:0] yo; logic [1:0] co; logic oo; exp_t e;
    do_reset();
    wr_coef(COEF_B0, 17'h08000);
    for (int i = 0; i < 2; i++) begin
      model_push(0, 17'h08000);
      run_sample(2'd0, 17'h08000, (i == 0) ? 2 : -1, COEF_B0, 17'h0FFFF,
                 seen, lat, rl, yo, co, oo);
      e = sb.pop_front();
      n_chk++;
      if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf} || yo !== 17'h04000)
        $display("FAIL busy_write[%0d] got v=%b y=%h expected y=04000", i, seen, yo);
      else n_pass++;
    end
    mcoef[0] = sx17(17'h04000);
    model_push(1, 17'h08000);
    run_sample(2'd1, 17'h08000, 0, COEF_B0, 17'h04000, seen, lat, rl, yo, co, oo);
    e = sb.pop_front();
    n_chk++;
    if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf} || yo !== 17'h02000)
      $display("FAIL same_edge_write got v=%b y=%h expected y=02000", seen, yo);
    else n_pass++;
  endtask

  // in_ch=3 is out of range with three channels.
  task automatic test_drop();
    bit seen; int lat, rl; logic [16:0] yo; logic [1:0] co; logic oo; exp_t e;
    do_reset();
    wr_coef(COEF_B0, 17'h08000);
    wr_coef(COEF_B1, 17'h08000);
    model_push(0, 17'h08000);
    run_sample(2'd0, 17'h08000, -1, 3'd0, 17'h0, seen, lat, rl, yo, co, oo);
    e = sb.pop_front();
    n_chk++;
    if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf})
      $display("FAIL drop_pre got v=%b y=%h expected y=%h", seen, yo, e.y);
    else n_pass++;
    model_push(3, 17'h0FFFF);
    run_sample(2'd3, 17'h0FFFF, -1, 3'd0, 17'h0, seen, lat, rl, yo, co, oo);
    n_chk++;
    if (seen !== 1'b0 || rl !== 6)
      $display("FAIL drop_ch got out_valid=%b ready_after=%0d expected 0 6", seen, rl);
    else n_pass++;
    model_push(0, 17'h0);
    run_sample(2'd0, 17'h0, -1, 3'd0, 17'h0, seen, lat, rl, yo, co, oo);
    e = sb.pop_front();
    n_chk++;
    if ({seen, co, yo, oo} !== {1'b1, e.ch, e.y, e.ovf} || yo !== 17'h04000)
      $display("FAIL drop_hist got v=%b y=%h expected y=04000", seen, yo);
    else n_pass++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.x         = '0;
    bus.coef_we   = 1'b0;
    bus.coef_sel  = '0;
    bus.coef_data = '0;
    test_reset();
    test_single();
    test_impulse();
    test_interleave();
    test_overflow();
    test_reset_mid();
    test_coef_write();
    test_drop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
